bus_arbiter_rr: RTL
===================

Name: bus_arbiter_rr

Overview:
- N-port round-robin arbiter sharing one memory-controller port among N per-hart BUS masters.
- Replaces the fixed two-port arbiter in multi-hart tops.
- Registers each granted request, forwards it downstream with the requester id, and routes the ack back.
- Keeps a grant locked across atomic sequences so the memory controller's reservation and AMO logic sees uninterrupted access.

Parameters:
N_PORTS, 4, number of requesters (2..8).
LOCK_MAX, 16, maximum idle cycles a lock is held before forced release.
ID_W, (N_PORTS>1 ? $clog2(N_PORTS) : 1), id width (localparam).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_bus_en  in  N_PORTS  per-port request; held until that port's o_ack.
i_wr_en  in  N_PORTS  per-port write(1)/read(0).
i_wr_data  in  N_PORTS*32  per-port write data; port k at [32k+31:32k].
i_addr  in  N_PORTS*32  per-port address.
i_byte_en  in  N_PORTS*4  per-port byte enables.
i_atomic  in  N_PORTS  per-port atomic/lock request.
i_operation  in  N_PORTS*7  per-port funct7 (AMO/LR/SC code).
o_ack  out  N_PORTS  one-cycle ack to granted port.
o_rd_data  out  N_PORTS*32  read data; granted port gets i_rd_data, others 0.
i_ack  in  1  downstream ack.
i_rd_data  in  32  downstream read data.
o_id  out  ID_W  id of granted port.
o_bus_en  out  1  downstream request.
o_wr_en  out  1  registered wr_en.
o_wr_data  out  32  registered write data.
o_addr  out  32  registered address.
o_byte_en  out  4  registered byte enables.
o_atomic  out  1  registered atomic flag.
o_operation  out  7  registered operation.
o_locked  out  1  high while in LOCKED.

Behaviour:
- Reset (synchronous, i_rst=1 at edge):
  - State=IDLE; last_grant=N_PORTS-1, so port 0 has priority.
  - Lock counter=0.
  - All registered outputs, o_id and o_locked are 0; o_ack=0; o_rd_data=0.
  - Reset mid-transaction aborts it; a downstream i_ack arriving later is ignored.
- States: IDLE, BUSY, LOCKED.
- IDLE:
  - If any i_bus_en is set, pick the first requesting port searching last_grant+1, +2, … mod N_PORTS.
  - Latch that port's wr_en/wr_data/addr/byte_en/atomic/operation into the output registers and its index into o_id.
  - Set last_grant=index; go BUSY.
  - o_bus_en rises the cycle after the request is sampled (1-cycle grant latency).
  - i_ack in IDLE is ignored.
- BUSY:
  - o_bus_en=1; outputs are stable, so later changes on port inputs have no effect.
  - On i_ack=1:
    - o_ack[o_id]=1 combinationally in the same cycle.
    - o_rd_data slice for o_id = i_rd_data in the same cycle; all other slices stay 0.
    - Next state: LOCKED if the latched o_atomic=1 AND i_atomic[o_id]=1 in the ack cycle, else IDLE.
    - o_bus_en=0 the next cycle.
  - Without i_ack, remain in BUSY indefinitely.
  - A requester dropping i_bus_en early is a protocol violation; the transaction still completes.
- LOCKED:
  - o_locked=1, o_bus_en=0; o_id is held; other ports are not granted.
  - If i_atomic[o_id]=0: go IDLE and clear the counter.
  - Else if i_bus_en[o_id]=1: latch that port's fields, go BUSY, clear the counter. last_grant is unchanged.
  - Else increment the counter. When the counter reaches LOCK_MAX-1, go IDLE (forced release) and clear the counter.
  - Release and atomic-drop take priority over a simultaneous new request. The request is then re-arbitrated from IDLE next cycle.
- A port re-requesting right after its ack (no lock) loses to any other pending port, giving round-robin fairness.
- Back-to-back throughput: one transaction per (downstream latency + 2) cycles.
- Only one transaction is outstanding; no queuing.

Test Plan:
- Single request: after reset, port 2 reads addr 0x100 → o_bus_en=1 with o_id=2 one cycle later. i_ack with i_rd_data=0xDEADBEEF → o_ack=4'b0100 and slice 2=0xDEADBEEF in the same cycle. Back to IDLE next cycle.
- Simultaneous requests after reset: ports 0,1,3 all request, each acked 1 cycle after grant → grant order 0,1,3. Ports 1 and 3 hold o_ack=0 until their turn.
- Fairness: all 4 ports request continuously for 8 transactions → o_id sequence 0,1,2,3,0,1,2,3.
- Atomic lock: port 1 issues LR (i_atomic=1, operation 0x08), acks, then SC 3 cycles later while port 0 requests throughout → o_locked=1 between them; SC is granted to port 1 before port 0. Port 1 drops i_atomic → IDLE, then port 0 is granted.
- Lock timeout: port 0 locks, then holds i_atomic=1 without re-requesting, with port 1 waiting → forced release after LOCK_MAX=16 cycles in LOCKED; port 1 granted next.
- Reset mid-op: assert i_rst during BUSY, then i_ack one cycle after reset deasserts → no o_ack pulses; all outputs 0; next request from port 0 is granted normally.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module   : bus_arbiter_rr
// Function : N-port round-robin BUS arbiter with atomic-sequence grant lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr #(
    parameter int N_PORTS  = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [N_PORTS-1:0]                          i_bus_en,
    input  logic [N_PORTS-1:0]                          i_wr_en,
    input  logic [N_PORTS*32-1:0]                       i_wr_data,
    input  logic [N_PORTS*32-1:0]                       i_addr,
    input  logic [N_PORTS*4-1:0]                        i_byte_en,
    input  logic [N_PORTS-1:0]                          i_atomic,
    input  logic [N_PORTS*7-1:0]                        i_operation,
    output logic [N_PORTS-1:0]                          o_ack,
    output logic [N_PORTS*32-1:0]                       o_rd_data,
    input  logic                                        i_ack,
    input  logic [31:0]                                 i_rd_data,
    output logic [((N_PORTS>1)?$clog2(N_PORTS):1)-1:0]  o_id,
    output logic                                        o_bus_en,
    output logic                                        o_wr_en,
    output logic [31:0]                                 o_wr_data,
    output logic [31:0]                                 o_addr,
    output logic [3:0]                                  o_byte_en,
    output logic                                        o_atomic,
    output logic [6:0]                                  o_operation,
    output logic                                        o_locked
);

    localparam int ID_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      byte_en_q, byte_en_d;
    logic            atomic_q, atomic_d;
    logic [6:0]      operation_q, operation_d;

    logic [ID_W:0]   w_pick_res;
    logic [ID_W-1:0] w_pick;
    logic            w_pick_vld;
    logic [ID_W-1:0] w_sel;
    logic            w_load;
    logic            w_ack_fire;

    // Scan from the farthest candidate toward the nearest so the nearest wins.
    function automatic logic [ID_W:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [ID_W-1:0]    last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (req[idx[ID_W-1:0]]) res = {1'b1, idx[ID_W-1:0]};
        end
        return res;
    endfunction

    assign w_pick_res = rr_pick(i_bus_en, last_q);
    assign w_pick_vld = w_pick_res[ID_W];
    assign w_pick     = w_pick_res[ID_W-1:0];
    assign w_sel      = (state_q == c_LOCKED) ? id_q : w_pick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= c_IDLE;
            last_q      <= ID_W'(N_PORTS - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            addr_q      <= '0;
            byte_en_q   <= '0;
            atomic_q    <= 1'b0;
            operation_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            addr_q      <= addr_d;
            byte_en_q   <= byte_en_d;
            atomic_q    <= atomic_d;
            operation_q <= operation_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        w_load      = 1'b0;
        wr_en_d     = wr_en_q;
        wr_data_d   = wr_data_q;
        addr_d      = addr_q;
        byte_en_d   = byte_en_q;
        atomic_d    = atomic_q;
        operation_d = operation_q;
        case (state_q)
            c_IDLE: begin
                if (w_pick_vld) begin
                    state_d = c_BUSY;
                    id_d    = w_pick;
                    last_d  = w_pick;
                    w_load  = 1'b1;
                end
            end
            c_BUSY: begin
                if (i_ack) begin
                    state_d = (atomic_q && i_atomic[id_q]) ? c_LOCKED : c_IDLE;
                    cnt_d   = '0;
                end
            end
            c_LOCKED: begin
                // Atomic drop and timeout beat a same-cycle request from the owner.
                if (!i_atomic[id_q] || (cnt_q == CNT_W'(LOCK_MAX - 1))) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end else if (i_bus_en[id_q]) begin
                    state_d = c_BUSY;
                    cnt_d   = '0;
                    w_load  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
        if (w_load) begin
            wr_en_d     = i_wr_en[w_sel];
            wr_data_d   = i_wr_data[32*w_sel +: 32];
            addr_d      = i_addr[32*w_sel +: 32];
            byte_en_d   = i_byte_en[4*w_sel +: 4];
            atomic_d    = i_atomic[w_sel];
            operation_d = i_operation[7*w_sel +: 7];
        end
    end

    assign w_ack_fire = (state_q == c_BUSY) && i_ack;

    always_comb begin
        o_bus_en  = (state_q == c_BUSY);
        o_locked  = (state_q == c_LOCKED);
        o_ack     = '0;
        o_rd_data = '0;
        if (w_ack_fire) begin
            o_ack[id_q]                = 1'b1;
            o_rd_data[32*id_q +: 32]   = i_rd_data;
        end
    end

    assign o_id        = id_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_data   = wr_data_q;
    assign o_addr      = addr_q;
    assign o_byte_en   = byte_en_q;
    assign o_atomic    = atomic_q;
    assign o_operation = operation_q;

endmodule

`default_nettype wire
